// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronises rx, validates the start bit, samples eight
// data bits LSB-first at mid-bit and checks the stop bit, emitting one-cycle strobes.
module uart_rx_deserializer #(
   parameter int CLOCK_SCALE_BITS = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [CLOCK_SCALE_BITS-1:0] cycles_per_bit,
   input  logic                        rx,
   output logic [7:0]                  data_out,
   output logic                        data_available,
   output logic                        frame_error
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   localparam logic [CLOCK_SCALE_BITS-1:0] MIN_PERIOD = CLOCK_SCALE_BITS'(3);
   localparam logic [CLOCK_SCALE_BITS-1:0] ONE        = CLOCK_SCALE_BITS'(1);

   logic [1:0]                  sync_reg;
   logic                        rx_s;

   logic [2:0]                  state_reg, state_next;
   logic [CLOCK_SCALE_BITS-1:0] period_reg, period_next;
   logic [CLOCK_SCALE_BITS-1:0] count_reg, count_next;
   logic [2:0]                  bit_reg, bit_next;
   logic [7:0]                  sh_reg, sh_next;
   logic [7:0]                  data_reg, data_next;
   logic                        avail_reg, avail_next;
   logic                        ferr_reg, ferr_next;

   logic [CLOCK_SCALE_BITS-1:0] half;
   logic [CLOCK_SCALE_BITS-1:0] period_clamped;

   assign rx_s           = sync_reg[1];
   assign half           = period_reg >> 1;
   // Very short periods would leave no room between the mid-start and first data sample.
   assign period_clamped = (cycles_per_bit < MIN_PERIOD) ? MIN_PERIOD : cycles_per_bit;

   always_comb begin
      state_next  = state_reg;
      period_next = period_reg;
      count_next  = count_reg + ONE;
      bit_next    = bit_reg;
      sh_next     = sh_reg;
      data_next   = data_reg;
      avail_next  = 1'b0;
      ferr_next   = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            count_next = '0;
            if (!rx_s) begin
               state_next  = ST_START;
               period_next = period_clamped;
            end
         end

         ST_START: begin
            if (count_reg == half) begin
               count_next = '0;
               if (!rx_s) begin
                  state_next = ST_DATA;
                  bit_next   = 3'd0;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end

         ST_DATA: begin
            if (count_reg == period_reg) begin
               count_next = '0;
               sh_next    = {rx_s, sh_reg[7:1]};
               bit_next   = bit_reg + 3'd1;
               if (bit_reg == 3'd7) begin
                  state_next = ST_STOP;
               end
            end
         end

         ST_STOP: begin
            // Returning to IDLE mid-stop-bit lets a back-to-back start edge be caught.
            if (count_reg == period_reg) begin
               count_next = '0;
               if (rx_s) begin
                  data_next  = sh_reg;
                  avail_next = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  ferr_next  = 1'b1;
                  state_next = ST_BREAK;
               end
            end
         end

         ST_BREAK: begin
            count_next = '0;
            if (rx_s) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
            count_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg   <= 2'b11;
         state_reg  <= ST_IDLE;
         period_reg <= MIN_PERIOD;
         count_reg  <= '0;
         bit_reg    <= 3'd0;
         sh_reg     <= 8'h00;
         data_reg   <= 8'h00;
         avail_reg  <= 1'b0;
         ferr_reg   <= 1'b0;
      end else begin
         sync_reg   <= {sync_reg[0], rx};
         state_reg  <= state_next;
         period_reg <= period_next;
         count_reg  <= count_next;
         bit_reg    <= bit_next;
         sh_reg     <= sh_next;
         data_reg   <= data_next;
         avail_reg  <= avail_next;
         ferr_reg   <= ferr_next;
      end
   end

   assign data_out       = data_reg;
   assign data_available = avail_reg;
   assign frame_error    = ferr_reg;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: frames are driven bit by bit and the
// expected byte/strobe kind/arrival cycle is queued, then checked as strobes appear.
module tb_uart_rx_deserializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cycles_per_bit = 16'd15;
   logic        rx = 1'b1;
   logic [7:0]  data_out;
   logic        data_available;
   logic        frame_error;

   uart_rx_deserializer #(.CLOCK_SCALE_BITS(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .cycles_per_bit (cycles_per_bit),
      .rx             (rx),
      .data_out       (data_out),
      .data_available (data_available),
      .frame_error    (frame_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int         kind;   // 1 = byte, 2 = frame error
      logic [7:0] b;
      int         when;   // consumer edge index at which the strobe is seen
   } exp_t;

   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Monitor: strobes are observed mid-cycle, the consuming edge is the next posedge.
   logic prev_strobe = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (data_available || frame_error) begin
         check("strobe_excl", 32'(data_available && frame_error), 32'd0);
         check("strobe_single", 32'(prev_strobe), 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_strobe", {30'd0, frame_error, data_available}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("kind", frame_error ? 32'd2 : 32'd1, 32'(e.kind));
            if (data_available) check("data", 32'(data_out), 32'(e.b));
            check("cycle", 32'(cyc + 1), 32'(e.when));
            $display("[TB] cycle %0d: %s data_out=0x%02h (expected kind %0d byte 0x%02h at %0d)",
                     cyc + 1, data_available ? "byte " : "ferr ", data_out, e.kind, e.b, e.when);
         end
      end
      prev_strobe = data_available || frame_error;
   end

   // All driver tasks start and end 1 time unit after a posedge.
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stop, input int p, input int exp_p,
                       input int kind, input int chg_bit = -1, input int chg_val = 0,
                       input int rst_bit = -1);
      exp_t e;
      int   n;
      n = cyc;
      if (kind != 0) begin
         e.kind = kind;
         e.b    = b;
         // first capture edge is n+1; stop sampled 3+half+9(p+1) later; +1 output register
         e.when = n + 1 + 3 + (exp_p >> 1) + 9 * (exp_p + 1) + 1;
         sb.push_back(e);
      end
      rx = 1'b0;
      idle(p + 1);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (i == chg_bit) begin
            idle((p + 1) / 2);
            cycles_per_bit = 16'(chg_val);
            idle(p + 1 - (p + 1) / 2);
         end else if (i == rst_bit) begin
            rst = 1'b1;
            idle(1);
            rst = 1'b0;
            idle(p);
         end else begin
            idle(p + 1);
         end
      end
      rx = stop;
      idle(p + 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle(3);
      check("rst_data_out", 32'(data_out), 32'h00);
      check("rst_avail", 32'(data_available), 32'd0);
      check("rst_ferr", 32'(frame_error), 32'd0);
      rst = 1'b0;
      idle(10);

      // single byte
      send(8'hA5, 1'b1, 15, 15, 1);
      idle(20);

      // back-to-back, no idle gap
      send(8'h00, 1'b1, 15, 15, 1);
      send(8'hFF, 1'b1, 15, 15, 1);
      idle(20);

      // glitch then a good byte
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      idle(40);
      send(8'h3C, 1'b1, 15, 15, 1);
      idle(20);

      // framing error, held break, recovery
      send(8'h55, 1'b0, 15, 15, 2);
      check("ferr_data_hold", 32'(data_out), 32'h3C);
      idle(300);
      rx = 1'b1;
      idle(30);
      check("break_data_hold", 32'(data_out), 32'h3C);
      send(8'h81, 1'b1, 15, 15, 1);
      idle(20);

      // reset during data bit 4 of 0xF0
      send(8'hF0, 1'b1, 15, 15, 0, -1, 0, 4);
      idle(20);
      check("rst_mid_data_out", 32'(data_out), 32'h00);
      send(8'h12, 1'b1, 15, 15, 1);
      idle(20);

      // period change mid-frame only affects the next frame
      send(8'h6B, 1'b1, 15, 15, 1, 2, 100);
      idle(50);
      send(8'h6B, 1'b1, 100, 100, 1);
      idle(50);

      // short period clamped to 3
      cycles_per_bit = 16'd1;
      idle(10);
      send(8'h5A, 1'b1, 3, 3, 1);
      idle(50);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
